adc_ep_tx: RTL and testbench

Streams samples from the 10-bit parallel ADC bus into the USB device controller's bulk IN endpoint. This is the device-to-host counterpart of the OUT-endpoint command path that drives the PWM outputs. Samples are taken on a programmable strobe, packed into two bytes each and buffered. Full packets are served through the controller's txact/txpop/txcork/txpktfin handshake, with rewind-on-retry.

---
 rtl/adc_ep_tx.sv | 163 ++++++++++++++++
 tb/tb_adc_ep_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ep_tx.sv
// ADC sample packer feeding a USB bulk IN endpoint.
// Buffers 2-byte samples and serves full packets with rewind-on-retry.
module adc_ep_tx #(
  parameter int EP_NUM     = 2,
  parameter int PKT_LEN    = 512,
  parameter int DEPTH_LOG2 = 11,
  parameter int SAMPLE_DIV = 60
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [9:0]            adc_data_i,
  input  logic [3:0]            endpt_i,
  input  logic                  txact_i,
  input  logic                  txpop_i,
  input  logic                  txpktfin_i,
  output logic [7:0]            txdat_o,
  output logic                  txval_o,
  output logic [11:0]           txdat_len_o,
  output logic                  txcork_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [15:0]           ovf_cnt_o
);

  localparam int AW = DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DW = $clog2(SAMPLE_DIV);

  typedef enum logic {WR_IDLE, WR_HI} wr_st_t;
  typedef enum logic [1:0] {RD_IDLE, RD_SEND, RD_DONE} rd_st_t;

  logic [9:0]    r_adc1, r_adc2;
  logic [DW-1:0] r_div;
  logic [5:0]    r_seq;
  logic [7:0]    r_hi;
  logic [15:0]   r_ovf;
  logic [PW-1:0] r_wr, r_spec, r_commit, r_sent;
  logic [11:0]   r_len;
  logic          r_txact_q;
  wr_st_t        r_wst;
  rd_st_t        r_rst;
  logic [7:0]    r_mem [2**AW];

  logic          w_stb, w_room, w_we, w_ep, w_pop;
  logic [7:0]    w_wdat;
  logic [PW-1:0] w_level, w_free, w_spec_nxt;

  assign w_stb      = en_i && (r_div == DW'(SAMPLE_DIV - 1));
  assign w_level    = r_wr - r_commit;
  assign w_free     = PW'(2**AW) - w_level;
  assign w_room     = w_free >= PW'(2);
  assign w_we       = (r_wst == WR_HI) ||
                      (r_wst == WR_IDLE && w_stb && w_room);
  assign w_wdat     = (r_wst == WR_HI) ? r_hi : r_adc2[7:0];
  assign w_ep       = endpt_i == 4'(EP_NUM);
  assign w_pop      = txval_o && txpop_i && w_ep;
  assign w_spec_nxt = r_spec + PW'(w_pop);

  assign txcork_o    = !(r_rst == RD_IDLE && w_ep &&
                         w_level >= PW'(PKT_LEN));
  assign txval_o     = (r_rst == RD_SEND) && (r_sent < PW'(PKT_LEN));
  assign txdat_o     = r_mem[r_spec[AW-1:0]];
  assign txdat_len_o = r_len;
  assign level_o     = w_level;
  assign ovf_cnt_o   = r_ovf;

  // Double-register the ADC bus before it is sampled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_adc1 <= '0;
      r_adc2 <= '0;
    end else begin
      r_adc1 <= adc_data_i;
      r_adc2 <= r_adc1;
    end
  end

  // Sample-rate divider; parked at zero while sampling is disabled.
  always_ff @(posedge clk_i) begin
    if (reset_i || !en_i)
      r_div <= '0;
    else if (r_div == DW'(SAMPLE_DIV - 1))
      r_div <= '0;
    else
      r_div <= r_div + DW'(1);
  end

  // Buffer storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk_i) begin
    if (w_we)
      r_mem[r_wr[AW-1:0]] <= w_wdat;
  end

  // Write FSM: low byte on the strobe, tagged high byte the cycle after.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wst <= WR_IDLE;
      r_wr  <= '0;
      r_seq <= '0;
      r_hi  <= '0;
      r_ovf <= '0;
    end else begin
      unique case (r_wst)
        WR_IDLE: begin
          if (w_stb) begin
            r_seq <= r_seq + 6'd1;
            if (w_room) begin
              r_wr  <= r_wr + PW'(1);
              r_hi  <= {r_seq, r_adc2[9:8]};
              r_wst <= WR_HI;
            end else if (r_ovf != 16'hFFFF) begin
              r_ovf <= r_ovf + 16'd1;
            end
          end
        end
        WR_HI: begin
          r_wr  <= r_wr + PW'(1);
          r_wst <= WR_IDLE;
        end
      endcase
    end
  end

  // Read FSM: speculative pops, commit on ACK, rewind on abandoned IN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rst     <= RD_IDLE;
      r_spec    <= '0;
      r_commit  <= '0;
      r_sent    <= '0;
      r_len     <= 12'(PKT_LEN);
      r_txact_q <= 1'b0;
    end else begin
      r_txact_q <= txact_i;
      unique case (r_rst)
        RD_IDLE: begin
          if (txact_i && !r_txact_q && !txcork_o) begin
            r_sent <= '0;
            r_len  <= 12'(PKT_LEN);
            r_rst  <= RD_SEND;
          end
        end
        RD_SEND: begin
          r_spec <= w_spec_nxt;
          r_sent <= r_sent + PW'(w_pop);
          if (txpktfin_i) begin
            r_commit <= w_spec_nxt;
            r_rst    <= RD_DONE;
          end else if (!txact_i) begin
            r_spec <= r_commit;
            r_rst  <= RD_IDLE;
          end
        end
        RD_DONE: begin
          if (!txact_i)
            r_rst <= RD_IDLE;
        end
        default: r_rst <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ep_tx.sv
// Scoreboard bench for adc_ep_tx.
// A reference packer fills a byte queue; IN reads are checked against it.
module tb_adc_ep_tx;

  logic        clk = 1'b0;
  logic        reset_i, en_i, txact_i, txpop_i, txpktfin_i;
  logic [9:0]  adc_data_i;
  logic [3:0]  endpt_i;
  logic [7:0]  txdat_o;
  logic        txval_o, txcork_o;
  logic [11:0] txdat_len_o;
  logic [11:0] level_o;
  logic [15:0] ovf_cnt_o;

  always #5 clk = ~clk;

  adc_ep_tx #(
    .EP_NUM(2), .PKT_LEN(512), .DEPTH_LOG2(11), .SAMPLE_DIV(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .adc_data_i(adc_data_i), .endpt_i(endpt_i),
    .txact_i(txact_i), .txpop_i(txpop_i), .txpktfin_i(txpktfin_i),
    .txdat_o(txdat_o), .txval_o(txval_o), .txdat_len_o(txdat_len_o),
    .txcork_o(txcork_o), .level_o(level_o), .ovf_cnt_o(ovf_cnt_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] q_exp[$];
  logic [7:0] cap[512];
  int         m_div = 0;
  int         m_nstb = 0;
  int         m_ovf = 0;
  logic [5:0] m_seq = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference packer: 4-cycle strobe, 2048-byte buffer, seq on every strobe.
  always @(posedge clk) begin
    if (reset_i) begin
      m_div  <= 0;
      m_seq  <= '0;
      m_ovf  <= 0;
      m_nstb <= 0;
      q_exp.delete();
    end else if (en_i) begin
      if (m_div == 3) begin
        m_div  <= 0;
        m_nstb <= m_nstb + 1;
        m_seq  <= m_seq + 6'd1;
        if (2048 - q_exp.size() >= 2) begin
          q_exp.push_back(adc_data_i[7:0]);
          q_exp.push_back({m_seq, adc_data_i[9:8]});
        end else if (m_ovf < 65535) begin
          m_ovf <= m_ovf + 1;
        end
      end else begin
        m_div <= m_div + 1;
      end
    end else begin
      m_div <= 0;
    end
  end

  task automatic wait_stb(input int n);
    int t = 0;
    while (m_nstb < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (m_nstb < n) chk("stb_timeout", 32'(m_nstb), 32'(n));
  endtask

  task automatic commit_q();
    repeat (512) void'(q_exp.pop_front());
  endtask

  task automatic do_in(input int np, input bit fin, input bit ccap);
    txact_i = 1'b1;
    @(negedge clk);
    chk("in_val", txval_o, 1);
    for (int i = 0; i < np; i++) begin
      if (i < 512) begin
        chk("in_dat", txdat_o, q_exp[i]);
        if (ccap) chk("retry_dat", txdat_o, cap[i]);
        else cap[i] = txdat_o;
      end else begin
        chk("val_end", txval_o, 0);
      end
      txpop_i = 1'b1;
      @(negedge clk);
    end
    txpop_i = 1'b0;
    if (fin) begin
      txpktfin_i = 1'b1;
      @(negedge clk);
      txpktfin_i = 1'b0;
      chk("done_val", txval_o, 0);
      chk("done_cork", txcork_o, 1);
    end
    txact_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_i    = 1'b1;
    en_i       = 1'b0;
    adc_data_i = 10'h2A5;
    endpt_i    = 4'd2;
    txact_i    = 1'b0;
    txpop_i    = 1'b0;
    txpktfin_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;

    repeat (100) @(negedge clk);
    chk("rst_cork", txcork_o, 1);
    chk("rst_level", level_o, 0);
    chk("rst_ovf", ovf_cnt_o, 0);
    chk("rst_val", txval_o, 0);
    chk("rst_len", txdat_len_o, 512);

    en_i = 1'b1;
    wait_stb(256);
    chk("cork_511", txcork_o, 1);
    @(negedge clk);
    chk("cork_512", txcork_o, 0);
    chk("len", txdat_len_o, 512);
    chk("lvl_512", level_o, 32'(q_exp.size()));
    chk("b0_const", txdat_o, 8'hA5);
    chk("b1_model", q_exp[1], 8'h02);
    endpt_i = 4'd0;
    #1;
    chk("cork_ep0", txcork_o, 1);
    endpt_i = 4'd2;
    wait_stb(768);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("lvl_1536", level_o, 1536);

    do_in(513, 1'b1, 1'b0);
    chk("lvl_fin", level_o, 1024);
    commit_q();
    chk("lvl_fin_m", level_o, 32'(q_exp.size()));
    chk("next_dat", txdat_o, q_exp[0]);

    do_in(512, 1'b0, 1'b0);
    chk("lvl_retry", level_o, 1024);
    chk("cork_retry", txcork_o, 0);
    chk("retry_b0", txdat_o, 8'hA5);
    do_in(512, 1'b1, 1'b1);
    chk("retry_b1", cap[1], 8'h02);
    commit_q();
    chk("lvl_512b", level_o, 512);

    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    en_i = 1'b1;
    wait_stb(1100);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovf_lvl", level_o, 2048);
    chk("ovf_cnt", ovf_cnt_o, 76);
    chk("ovf_cnt_m", ovf_cnt_o, 32'(m_ovf));
    chk("ovf_cork", txcork_o, 0);
    do_in(512, 1'b1, 1'b0);
    commit_q();
    en_i = 1'b1;
    wait_stb(1356);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("refill_lvl", level_o, 2048);
    chk("refill_ovf", ovf_cnt_o, 76);
    for (int p = 0; p < 3; p++) begin
      do_in(512, 1'b1, 1'b0);
      commit_q();
    end
    do_in(512, 1'b1, 1'b0);
    commit_q();
    chk("gap_b0", cap[0], 8'hA5);
    chk("gap_seq", cap[1], 8'h32);
    chk("drain_lvl", level_o, 0);

    en_i = 1'b1;
    wait_stb(1612);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    txact_i = 1'b1;
    @(negedge clk);
    chk("mid_val", txval_o, 1);
    txpop_i = 1'b1;
    repeat (100) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("mid_cork", txcork_o, 1);
    chk("mid_level", level_o, 0);
    chk("mid_val0", txval_o, 0);
    reset_i = 1'b0;
    txpop_i = 1'b0;
    txact_i = 1'b0;
    @(negedge clk);
    en_i = 1'b1;
    wait_stb(256);
    @(negedge clk);
    en_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("re_lvl", level_o, 512);
    chk("re_b0", txdat_o, 8'hA5);
    do_in(512, 1'b1, 1'b0);
    commit_q();
    chk("re_b1", cap[1], 8'h02);
    chk("re_b3", cap[3], 8'h06);
    chk("re_b5", cap[5], 8'h0A);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
